// File: rtl/jif_bus_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package  : jif_bus_pkg
// Purpose  : Shared constants, state encoding and lane helper for the 8-bit
//            serialized CPU bus (used by both responder and serializer).
// Revision : 1.0  initial release
// ============================================================================
package jif_bus_pkg;

    localparam int          NBYTES    = 4;
    localparam int          WORD_W    = 8 * NBYTES;
    localparam int          FRAME_LEN = 2 * NBYTES + 2;
    localparam int          IDX_W     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [7:0]  ERR_BYTE  = 8'hEE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    function automatic logic [7:0] lane_sel(input logic [WORD_W-1:0] word,
                                            input logic [IDX_W-1:0]  idx);
        return word[8*idx +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/jif_bus_responder_byte_deser.sv
`default_nettype none
// ============================================================================
// Module   : bus_byte_deser
// Purpose  : Byte-lane word register; writes byte_i into lane idx_i when en_i.
// Revision : 1.0  initial release
// ============================================================================
module bus_byte_deser
    import jif_bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o
);

    for (genvar g = 0; g < NBYTES; g++) begin : g_lane
        logic [7:0] lane_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                lane_q <= 8'h00;
            end else if (en_i && (idx_i == IDX_W'(g))) begin
                lane_q <= byte_i;
            end
        end

        assign word_o[8*g +: 8] = lane_q;
    end

endmodule
`default_nettype wire

// File: rtl/jif_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : jif_bus_responder
// Purpose  : Memory-side end of the serialized CPU bus: deserializes request
//            beats, issues one memory access, serializes the read response.
// Revision : 1.0  initial release
// ============================================================================
module jif_bus_responder
    import jif_bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_sync,
    input  logic              bus_rw,
    input  logic [7:0]        bus_addr_byte,
    input  logic [7:0]        bus_data_in,
    output logic [7:0]        bus_data_out,
    output logic              bus_data_oe,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       frame_cnt,
    output logic              err_late,
    output logic              err_abort
);

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NBYTES - 1);

    state_e              state_q,     state_d;
    logic [IDX_W-1:0]    beat_q,      beat_d;
    logic                rw_q,        rw_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [WORD_W-1:0]   rbuf_q,      rbuf_d;
    logic [7:0]          dout_q,      dout_d;
    logic                oe_q,        oe_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic                err_late_q,  err_late_d;
    logic                err_abort_q, err_abort_d;

    logic                w_rw_cur;
    logic                w_req_en;
    logic                w_wdata_en;
    logic [IDX_W-1:0]    w_next_beat;
    logic [WORD_W-1:0]   w_rdata;

    // rw is only valid on the bus during beat 0; later beats use the latched copy
    assign w_rw_cur    = (beat_q == '0) ? bus_rw : rw_q;
    assign w_req_en    = (state_q == REQ) && !bus_sync;
    assign w_wdata_en  = w_req_en && w_rw_cur;
    assign w_next_beat = beat_q + 1'b1;
    assign w_rdata     = mem_ready ? mem_rdata : {NBYTES{ERR_BYTE}};

    bus_byte_deser u_addr_deser (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (w_req_en),
        .idx_i  (beat_q),
        .byte_i (bus_addr_byte),
        .word_o (mem_addr)
    );

    bus_byte_deser u_wdata_deser (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (w_wdata_en),
        .idx_i  (beat_q),
        .byte_i (bus_data_in),
        .word_o (mem_wdata)
    );

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        rw_d        = rw_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        rbuf_d      = rbuf_q;
        dout_d      = dout_q;
        oe_d        = oe_q;
        frame_cnt_d = frame_cnt_q;
        err_late_d  = err_late_q;
        err_abort_d = err_abort_q;

        if (bus_sync && (state_q != IDLE)) begin
            // A new frame start mid-frame wins over whatever the frame was doing
            err_abort_d = 1'b1;
            state_d     = REQ;
            beat_d      = '0;
            oe_d        = 1'b0;
            dout_d      = 8'h00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus_sync) begin
                        state_d = REQ;
                        beat_d  = '0;
                    end
                end
                REQ: begin
                    if (beat_q == '0) begin
                        rw_d = bus_rw;
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d   = ACCESS;
                        mem_req_d = 1'b1;
                        mem_we_d  = w_rw_cur;
                    end else begin
                        beat_d = w_next_beat;
                    end
                end
                ACCESS: begin
                    rbuf_d  = w_rdata;
                    state_d = RESP;
                    beat_d  = '0;
                    oe_d    = !rw_q;
                    dout_d  = rw_q ? 8'h00 : w_rdata[7:0];
                    if (!mem_ready) begin
                        err_late_d = 1'b1;
                    end
                end
                RESP: begin
                    if (beat_q == LAST_BEAT) begin
                        state_d     = IDLE;
                        oe_d        = 1'b0;
                        dout_d      = 8'h00;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        beat_d = w_next_beat;
                        dout_d = rw_q ? 8'h00 : lane_sel(rbuf_q, w_next_beat);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            rw_q        <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            rbuf_q      <= '0;
            dout_q      <= 8'h00;
            oe_q        <= 1'b0;
            frame_cnt_q <= 16'h0000;
            err_late_q  <= 1'b0;
            err_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            rw_q        <= rw_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            rbuf_q      <= rbuf_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
            frame_cnt_q <= frame_cnt_d;
            err_late_q  <= err_late_d;
            err_abort_q <= err_abort_d;
        end
    end

    assign bus_data_out = dout_q;
    assign bus_data_oe  = oe_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_late     = err_late_q;
    assign err_abort    = err_abort_q;

endmodule
`default_nettype wire

// File: tb/tb_jif_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_jif_bus_responder
// Purpose  : Self-checking bench for jif_bus_responder: drives whole bus frames
//            and compares every beat against frame-level expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_jif_bus_responder;
    import jif_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_sync = 1'b0;
    logic        bus_rw = 1'b0;
    logic [7:0]  bus_addr_byte = 8'h00;
    logic [7:0]  bus_data_in = 8'h00;
    logic [7:0]  bus_data_out;
    logic        bus_data_oe;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;
    logic [15:0] frame_cnt;
    logic        err_late;
    logic        err_abort;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] exp_fc    = 16'h0;
    logic        exp_late  = 1'b0;
    logic        exp_abort = 1'b0;

    always #5 clk = ~clk;

    jif_bus_responder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_sync      (bus_sync),
        .bus_rw        (bus_rw),
        .bus_addr_byte (bus_addr_byte),
        .bus_data_in   (bus_data_in),
        .bus_data_out  (bus_data_out),
        .bus_data_oe   (bus_data_oe),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .frame_cnt     (frame_cnt),
        .err_late      (err_late),
        .err_abort     (err_abort)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_flags();
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        chk("err_late",  32'(err_late),  32'(exp_late));
        chk("err_abort", 32'(err_abort), 32'(exp_abort));
    endtask

    // mode: -1 full frame, 0..3 sync again at REQ beat k, 10..13 sync again at
    // RESP beat k-10, 20..23 reset pulse at RESP beat k-20.
    task automatic frame(input bit rw, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input bit ready, input bit presynced,
                         input int mode, output bit synced_out);
        logic [31:0] resp;
        synced_out = 1'b0;
        if (!presynced) begin
            @(negedge clk);
            chk("idle_oe",   32'(bus_data_oe), 32'(0));
            chk("idle_dout", 32'(bus_data_out), 32'(0));
            chk("idle_req",  32'(mem_req), 32'(0));
            check_flags();
            bus_sync      = 1'b1;
            bus_addr_byte = 8'($urandom);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("req_oe",   32'(bus_data_oe), 32'(0));
            chk("req_dout", 32'(bus_data_out), 32'(0));
            chk("req_mem_req", 32'(mem_req), 32'(0));
            chk("err_abort", 32'(err_abort), 32'(exp_abort));
            if (mode == k) begin
                bus_sync   = 1'b1;
                exp_abort  = 1'b1;
                synced_out = 1'b1;
                return;
            end
            bus_sync      = 1'b0;
            bus_rw        = (k == 0) ? rw : 1'($urandom);
            bus_addr_byte = addr[8*k +: 8];
            bus_data_in   = rw ? wdata[8*k +: 8] : 8'($urandom);
            mem_ready     = 1'($urandom);
            mem_rdata     = $urandom;
        end
        @(negedge clk);
        chk("acc_mem_req", 32'(mem_req), 32'(1));
        chk("acc_mem_we",  32'(mem_we), 32'(rw));
        chk("acc_addr",    mem_addr, addr);
        if (rw) chk("acc_wdata", mem_wdata, wdata);
        chk("acc_oe", 32'(bus_data_oe), 32'(0));
        bus_rw    = 1'($urandom);
        mem_rdata = rdata;
        mem_ready = ready;
        if (!ready) exp_late = 1'b1;
        resp = ready ? rdata : {4{ERR_BYTE}};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("resp_mem_req", 32'(mem_req), 32'(0));
            chk("resp_oe",   32'(bus_data_oe), 32'(!rw));
            chk("resp_dout", 32'(bus_data_out), rw ? 32'(0) : 32'(resp[8*k +: 8]));
            chk("resp_addr", mem_addr, addr);
            chk("err_late",  32'(err_late), 32'(exp_late));
            mem_ready = 1'($urandom);
            mem_rdata = $urandom;
            if (mode == 10 + k) begin
                bus_sync   = 1'b1;
                exp_abort  = 1'b1;
                synced_out = 1'b1;
                return;
            end
            if (mode == 20 + k) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n     = 1'b1;
                exp_fc    = 16'h0;
                exp_late  = 1'b0;
                exp_abort = 1'b0;
                chk("rst_oe",   32'(bus_data_oe), 32'(0));
                chk("rst_dout", 32'(bus_data_out), 32'(0));
                chk("rst_addr", mem_addr, 32'(0));
                check_flags();
                return;
            end
        end
        exp_fc = exp_fc + 16'd1;
    endtask

    initial begin
        bit          s;
        bit          rw;
        bit          rdy;
        int          mode;
        logic [31:0] a, w, r;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'(0));
        chk("rst_mem_we",  32'(mem_we), 32'(0));
        chk("rst_addr",    mem_addr, 32'(0));
        chk("rst_wdata",   mem_wdata, 32'(0));
        chk("rst_oe",      32'(bus_data_oe), 32'(0));
        chk("rst_dout",    32'(bus_data_out), 32'(0));
        check_flags();
        rst_n = 1'b1;

        // Basic read, basic write, late memory
        frame(1'b0, 32'h12345678, 32'h0, 32'hCAFEBABE, 1'b1, 1'b0, -1, s);
        frame(1'b1, 32'h00000010, 32'h11223344, $urandom, 1'b1, 1'b0, -1, s);
        frame(1'b0, $urandom, 32'h0, $urandom, 1'b0, 1'b0, -1, s);

        // Abort at REQ beat 2 then a fresh frame with no stale address bytes
        frame(1'b0, 32'hFFFFFFFF, 32'h0, $urandom, 1'b1, 1'b0, 2, s);
        frame(1'b0, 32'hA1B2C3D4, 32'h0, 32'h0BADF00D, 1'b1, s, -1, s);

        // Back-to-back reads
        for (int i = 0; i < 3; i++)
            frame(1'b0, $urandom, 32'h0, $urandom, 1'b1, 1'b0, -1, s);

        // Abort while driving response, then recovery
        frame(1'b0, $urandom, 32'h0, $urandom, 1'b1, 1'b0, 11, s);
        frame(1'b1, $urandom, $urandom, $urandom, 1'b1, s, -1, s);

        // Reset during RESP beat 1, then a normal frame
        frame(1'b0, $urandom, 32'h0, $urandom, 1'b1, 1'b0, 21, s);
        frame(1'b0, $urandom, 32'h0, $urandom, 1'b1, 1'b0, -1, s);

        // Randomized frames, occasionally aborted
        s = 1'b0;
        for (int i = 0; i < 24; i++) begin
            rw   = 1'($urandom);
            rdy  = ($urandom_range(3, 0) != 0);
            a    = $urandom;
            w    = $urandom;
            r    = $urandom;
            case ($urandom_range(7, 0))
                0:       mode = $urandom_range(3, 0);
                1:       mode = 10 + $urandom_range(3, 0);
                default: mode = -1;
            endcase
            frame(rw, a, w, r, rdy, s, mode, s);
        end
        if (s) frame(1'b0, $urandom, 32'h0, $urandom, 1'b1, s, -1, s);
        @(negedge clk);
        check_flags();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
